usb_mem_readback: RTL and testbench

- Upload path of the USB interface. Reads 128-bit pattern words back from pattern memory and unpacks each into eight 16-bit words.
- Drives the words out to the FX2 slave FIFO (host IN endpoint) so the host can verify stored DMD patterns.
- Sits in the ifclk domain beside the USB download packer. The memory read port is already synchronised to ifclk by the memory controller wrapper.

---
 rtl/usb_mem_readback_pkg.sv | 33 +++
 rtl/usb_rb_fifo.sv | 55 +++++
 rtl/usb_mem_readback.sv | 195 +++++++++++++++++++
 tb/tb_usb_mem_readback.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_mem_readback_pkg.sv
// Shared definitions for the USB upload (readback) path: FSM encoding, FX2 strobe
// polarity, lane ordering shared with the download packer, and packet defaults.
package usb_mem_readback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_PKTEND = 2'd2,
        ST_FINISH = 2'd3
    } rb_state_t;

    // FX2 SLWR / PKTEND are active low
    localparam logic FX2_ASSERT = 1'b0;
    localparam logic FX2_IDLE   = 1'b1;

    localparam int LANE_W = 16;
    localparam int LANES  = 8;

    // Bits [15:0] travel first; must stay identical to the download packer
    localparam bit LANE_LSB_FIRST = 1'b1;

    localparam int PKT_WORDS_DEFAULT = 256;

    function automatic logic [LANE_W-1:0] lane_pick(
        input logic [LANES*LANE_W-1:0] word,
        input logic [2:0]              lane
    );
        logic [2:0] idx;
        idx = LANE_LSB_FIRST ? lane : (3'(LANES - 1) - lane);
        return word[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/usb_rb_fifo.sv
// Return buffer for 128-bit memory words. Read data is presented combinationally
// from the head entry so the serializer can reload without a bubble.
module usb_rb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_wr && !do_rd)      count_reg <= count_reg + 1'b1;
            else if (do_rd && !do_wr) count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/usb_mem_readback.sv
// Reads 128-bit pattern words back from memory and streams them as 16-bit words
// into the FX2 IN FIFO, committing any trailing short packet with PKTEND.
module usb_mem_readback
    import usb_mem_readback_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int PKT_WORDS = PKT_WORDS_DEFAULT,
    parameter int LEN_W     = 24
) (
    input  logic             ifclk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] rd_len,
    output logic             mem_rd_req,
    input  logic [127:0]     mem_rd_data,
    input  logic             mem_rd_data_valid,
    input  logic             usb_full_n,
    output logic [15:0]      usb_dout,
    output logic             usb_wr_n,
    output logic             usb_pktend_n,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int PW = $clog2(PKT_WORDS);
    localparam logic [CW:0]   DEPTH_V   = (CW+1)'(BUF_DEPTH);
    localparam logic [PW-1:0] PKT_LAST  = PW'(PKT_WORDS - 1);

    rb_state_t        state_reg, state_next;
    logic [LEN_W-1:0] req_left_reg;
    logic [LEN_W-1:0] word_left_reg;
    logic [CW-1:0]    outstanding_reg;
    logic [PW-1:0]    pkt_cnt_reg;
    logic [127:0]     ser_word_reg;
    logic             ser_valid_reg;
    logic [2:0]       lane_reg;
    logic             wr_n_reg;
    logic             pktend_n_reg;
    logic [15:0]      dout_reg;
    logic             overflow_reg;

    logic [127:0]     fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      occupancy;
    logic             start_ok;
    logic             abort_take;
    logic             in_stream;
    logic             write_now;
    logic             last_lane;
    logic             ser_load;
    logic             fifo_wr;
    logic             pktend_fire;

    assign in_stream  = (state_reg == ST_STREAM);
    assign start_ok   = (state_reg == ST_IDLE) && start && (outstanding_reg == '0);
    assign abort_take = abort && ((state_reg == ST_STREAM) || (state_reg == ST_PKTEND));
    assign occupancy  = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign last_lane  = (lane_reg == 3'd7);
    assign write_now  = in_stream && ser_valid_reg && usb_full_n && !abort;
    assign ser_load   = in_stream && !abort && !fifo_empty &&
                        (!ser_valid_reg || (write_now && last_lane));
    // Returns are only buffered while streaming; late returns after abort are dropped
    assign fifo_wr    = mem_rd_data_valid && in_stream;

    usb_rb_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (128)
    ) u_fifo (
        .clk     (ifclk),
        .rst_n   (reset_n),
        .flush   (abort_take),
        .wr_en   (fifo_wr),
        .wr_data (mem_rd_data),
        .rd_en   (ser_load),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start_ok) state_next = (rd_len != '0) ? ST_STREAM : ST_FINISH;
            end
            ST_STREAM: begin
                if (abort)                    state_next = ST_FINISH;
                else if (word_left_reg == '0) state_next = (pkt_cnt_reg != '0) ? ST_PKTEND : ST_FINISH;
            end
            ST_PKTEND: begin
                if (abort || usb_full_n) state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_req  = 1'b0;
        pktend_fire = 1'b0;
        unique case (state_reg)
            ST_STREAM: begin
                busy       = 1'b1;
                mem_rd_req = (req_left_reg != '0) && (occupancy < DEPTH_V);
            end
            ST_PKTEND: begin
                busy        = 1'b1;
                pktend_fire = usb_full_n && !abort;
            end
            ST_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    // Request credit and length bookkeeping
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            req_left_reg    <= '0;
            word_left_reg   <= '0;
            outstanding_reg <= '0;
            pkt_cnt_reg     <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            if (mem_rd_req && !mem_rd_data_valid)
                outstanding_reg <= outstanding_reg + CW'(1);
            else if (!mem_rd_req && mem_rd_data_valid && (outstanding_reg != '0))
                outstanding_reg <= outstanding_reg - CW'(1);

            if (start_ok) begin
                req_left_reg  <= rd_len;
                word_left_reg <= rd_len;
                pkt_cnt_reg   <= '0;
                overflow_reg  <= 1'b0;
            end else if (abort_take) begin
                req_left_reg  <= '0;
                word_left_reg <= '0;
            end else begin
                if (mem_rd_req)             req_left_reg  <= req_left_reg - LEN_W'(1);
                if (write_now && last_lane) word_left_reg <= word_left_reg - LEN_W'(1);
                if (write_now) pkt_cnt_reg <= (pkt_cnt_reg == PKT_LAST) ? '0 : pkt_cnt_reg + PW'(1);
                if (fifo_wr && fifo_full) overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            ser_word_reg  <= '0;
            ser_valid_reg <= 1'b0;
            lane_reg      <= '0;
        end else if (abort_take || start_ok) begin
            ser_valid_reg <= 1'b0;
            lane_reg      <= '0;
        end else begin
            if (write_now) lane_reg <= lane_reg + 3'd1;
            if (ser_load) begin
                ser_word_reg  <= fifo_rd_data;
                ser_valid_reg <= 1'b1;
            end else if (write_now && last_lane) begin
                ser_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_n_reg     <= FX2_IDLE;
            pktend_n_reg <= FX2_IDLE;
            dout_reg     <= '0;
        end else begin
            wr_n_reg     <= write_now ? FX2_ASSERT : FX2_IDLE;
            pktend_n_reg <= pktend_fire ? FX2_ASSERT : FX2_IDLE;
            if (write_now) dout_reg <= lane_pick(ser_word_reg, lane_reg);
        end
    end

    assign usb_wr_n     = wr_n_reg;
    assign usb_pktend_n = pktend_n_reg;
    assign usb_dout     = dout_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_usb_mem_readback.sv
// Randomized bench for usb_mem_readback: a latency-modelled memory plus a
// queue of expected 16-bit host words derived from each returned 128-bit word.
module tb_usb_mem_readback;

    logic         ifclk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         abort;
    logic [23:0]  rd_len;
    logic         mem_rd_req;
    logic [127:0] mem_rd_data;
    logic         mem_rd_data_valid;
    logic         usb_full_n;
    logic [15:0]  usb_dout;
    logic         usb_wr_n;
    logic         usb_pktend_n;
    logic         busy;
    logic         done;
    logic         overflow;

    usb_mem_readback dut (
        .ifclk             (ifclk),
        .reset_n           (reset_n),
        .start             (start),
        .abort             (abort),
        .rd_len            (rd_len),
        .mem_rd_req        (mem_rd_req),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_data_valid (mem_rd_data_valid),
        .usb_full_n        (usb_full_n),
        .usb_dout          (usb_dout),
        .usb_wr_n          (usb_wr_n),
        .usb_pktend_n      (usb_pktend_n),
        .busy              (busy),
        .done              (done),
        .overflow          (overflow)
    );

    always #5 ifclk = ~ifclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    int n_wr, n_pkt, n_done, n_req, gaps, last_wr_cyc;
    int stall_at1 = -1, stall_at2 = -1, stall_cnt = 0;
    int abort_at = -1, wr_at_abort = 0, clr_cnt = 0;
    bit abort_sent, pattern_mode, rand_full, hold_full, force_extra;
    logic [15:0]  exp_q[$];
    logic [127:0] ret_q[$];
    int           due_q[$];

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [127:0] make_word(input int idx);
        logic [127:0] w;
        for (int k = 0; k < 8; k++)
            w[16*k +: 16] = pattern_mode ? 16'(idx*8 + k) : 16'($urandom);
        return w;
    endfunction

    task automatic clear_counts();
        n_wr = 0; n_pkt = 0; n_done = 0; n_req = 0; gaps = 0; last_wr_cyc = 0;
        abort_sent = 1'b0;
    endtask

    // One clock: observe at the falling edge, then drive inputs for the next rising edge
    task automatic step();
        logic [127:0] w;
        @(negedge ifclk);
        cyc++;
        if (usb_wr_n == 1'b0) begin
            if (exp_q.size() == 0) chk_eq("spurious_write", 64'(exp_q.size()), 64'(1));
            else                   chk_eq("usb_dout", 64'(usb_dout), 64'(exp_q.pop_front()));
            if (n_wr > 0 && cyc != last_wr_cyc + 1) gaps++;
            last_wr_cyc = cyc;
            n_wr++;
            $display("wr  cyc=%0d n=%0d dout=%04h", cyc, n_wr, usb_dout);
        end
        if (usb_pktend_n == 1'b0) n_pkt++;
        if (done) n_done++;
        if (mem_rd_req) begin
            w = make_word(n_req);
            n_req++;
            ret_q.push_back(w);
            due_q.push_back(cyc + lat);
            for (int k = 0; k < 8; k++) exp_q.push_back(w[16*k +: 16]);
        end
        if (clr_cnt > 0) begin
            clr_cnt--;
            if (clr_cnt == 0) exp_q.delete();
        end
        abort = 1'b0;
        if (abort_at >= 0 && !abort_sent && busy && n_wr >= abort_at) begin
            abort = 1'b1; abort_sent = 1'b1; wr_at_abort = n_wr; clr_cnt = 2;
        end
        if (stall_at1 >= 0 && n_wr >= stall_at1) begin stall_cnt = 10; stall_at1 = -1; end
        if (stall_at2 >= 0 && n_wr >= stall_at2) begin stall_cnt = 10; stall_at2 = -1; end
        if (stall_cnt > 0) begin usb_full_n = 1'b0; stall_cnt--; end
        else if (rand_full) usb_full_n = ($urandom_range(0, 3) != 0);
        else                usb_full_n = !hold_full;
        mem_rd_data_valid = 1'b0;
        if (force_extra) begin
            mem_rd_data_valid = 1'b1;
            mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
            force_extra = 1'b0;
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            mem_rd_data_valid = 1'b1;
            mem_rd_data = ret_q.pop_front();
            void'(due_q.pop_front());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_mem_rd_req"},   64'(mem_rd_req),   64'(0));
        chk_eq({tag, "_usb_wr_n"},     64'(usb_wr_n),     64'(1));
        chk_eq({tag, "_usb_pktend_n"}, 64'(usb_pktend_n), 64'(1));
        chk_eq({tag, "_usb_dout"},     64'(usb_dout),     64'(0));
        chk_eq({tag, "_busy"},         64'(busy),         64'(0));
        chk_eq({tag, "_done"},         64'(done),         64'(0));
        chk_eq({tag, "_overflow"},     64'(overflow),     64'(0));
    endtask

    task automatic run_xfer(input int len);
        int budget;
        clear_counts();
        rd_len = 24'(len);
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk_eq("busy_after_start", 64'(busy), 64'(len != 0));
        chk_eq("done_after_start", 64'(done), 64'(len == 0));
        budget = 60 * len + 400;
        while (n_done == 0 && budget > 0) begin step(); budget--; end
        repeat (4) step();
        $display("xfer len=%0d writes=%0d reqs=%0d pktend=%0d done=%0d", len, n_wr, n_req, n_pkt, n_done);
        chk_eq("done_count",   64'(n_done), 64'(1));
        chk_eq("write_count",  64'(n_wr),   64'(8*len));
        chk_eq("req_count",    64'(n_req),  64'(len));
        chk_eq("pktend_count", 64'(n_pkt),  64'(((8*len) % 256) != 0));
        chk_eq("words_left",   64'(exp_q.size()), 64'(0));
        chk_eq("overflow",     64'(overflow), 64'(0));
    endtask

    initial begin
        int wr_before;
        int budget;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; rd_len = '0;
        mem_rd_data = '0; mem_rd_data_valid = 1'b0; usb_full_n = 1'b1;
        pattern_mode = 1'b0; rand_full = 1'b0; hold_full = 1'b0; force_extra = 1'b0;
        clear_counts();
        repeat (3) @(negedge ifclk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) step();

        // Single word with a known pattern: 0000..0007 then a short-packet commit
        pattern_mode = 1'b1; lat = 2;
        run_xfer(1);
        chk_eq("single_gaps", 64'(gaps), 64'(0));
        pattern_mode = 1'b0;

        // Exactly one full packet, memory fast enough to never starve the FIFO
        lat = 1;
        run_xfer(32);
        chk_eq("full_packet_gaps", 64'(gaps), 64'(0));

        // Slower memory with two host-side stalls
        lat = 5; stall_at1 = 100; stall_at2 = 300;
        run_xfer(40);

        // Zero length goes straight to completion
        run_xfer(0);

        // Abort mid-transfer with slow returns still in flight
        lat = 20; abort_at = 50;
        clear_counts();
        rd_len = 24'd16; start = 1'b1; step(); start = 1'b0;
        budget = 2000;
        while (n_done == 0 && budget > 0) begin step(); budget--; end
        repeat (2) step();
        $display("abort writes=%0d at_abort=%0d pending=%0d", n_wr, wr_at_abort, ret_q.size());
        abort_at = -1;
        chk_eq("abort_done",      64'(n_done), 64'(1));
        chk_eq("abort_no_pktend", 64'(n_pkt),  64'(0));
        chk_eq("abort_stop",      64'(n_wr - wr_at_abort <= 1), 64'(1));
        wr_before = n_wr;
        if (ret_q.size() > 0) begin
            rd_len = 24'd1; start = 1'b1; step(); start = 1'b0;
            chk_eq("start_blocked_busy", 64'(busy), 64'(0));
            chk_eq("start_blocked_done", 64'(done), 64'(0));
        end
        budget = 200;
        while (ret_q.size() > 0 && budget > 0) begin step(); budget--; end
        repeat (3) step();
        chk_eq("late_returns_dropped", 64'(n_wr),     64'(wr_before));
        chk_eq("abort_overflow",       64'(overflow), 64'(0));
        lat = 3;
        run_xfer(2);

        // Host FIFO full: fill the buffer, then force one surplus return
        lat = 1; hold_full = 1'b1;
        clear_counts();
        rd_len = 24'd8; start = 1'b1; step(); start = 1'b0;
        repeat (20) step();
        chk_eq("credit_reqs",  64'(n_req),    64'(5));
        chk_eq("ovf_before",   64'(overflow), 64'(0));
        force_extra = 1'b1;
        step();
        step();
        chk_eq("overflow_set",    64'(overflow), 64'(1));
        repeat (5) step();
        chk_eq("overflow_sticky", 64'(overflow), 64'(1));
        chk_eq("busy_mid",        64'(busy),     64'(1));
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        exp_q.delete(); ret_q.delete(); due_q.delete();
        hold_full = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();

        // Randomized lengths, latencies and host back-pressure
        rand_full = 1'b1;
        for (int t = 0; t < 5; t++) begin
            lat = $urandom_range(1, 6);
            run_xfer($urandom_range(1, 12));
        end
        rand_full = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
